// File: rtl/i2c_bit_ctrl_if.sv
// Command/response handshake and open-drain line signals of the I2C bit engine.
// slave is the engine's view; master is the view of the byte layer and the pads.
interface i2c_bit_ctrl_if;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [1:0] cmd_i;
    logic       cmd_bit_i;
    logic       rsp_valid_o;
    logic       rsp_bit_o;
    logic       arb_lost_o;
    logic       busy_o;
    logic       scl_i;
    logic       sda_i;
    logic       scl_oe_o;
    logic       sda_oe_o;

    modport slave (
        input  cmd_valid_i, cmd_i, cmd_bit_i, scl_i, sda_i,
        output cmd_ready_o, rsp_valid_o, rsp_bit_o, arb_lost_o, busy_o,
               scl_oe_o, sda_oe_o
    );

    modport master (
        output cmd_valid_i, cmd_i, cmd_bit_i, scl_i, sda_i,
        input  cmd_ready_o, rsp_valid_o, rsp_bit_o, arb_lost_o, busy_o,
               scl_oe_o, sda_oe_o
    );
endinterface

// File: rtl/i2c_bit_ctrl.sv
// I2C master bit engine: executes START, STOP, WRITE or READ over four
// quarter-bit phases, with clock stretching and arbitration-loss detection.
module i2c_bit_ctrl (
    input  logic          clk_i,
    input  logic          arstn_i,
    input  logic          tick_i,
    i2c_bit_ctrl_if.slave bus
);
    // ST_ARM holds an accepted command until the first tick starts phase A.
    typedef enum logic [2:0] {
        ST_IDLE, ST_ARM, ST_PH_A, ST_PH_B, ST_PH_C, ST_PH_D
    } state_t;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_STOP  = 2'd1,
        CMD_WRITE = 2'd2,
        CMD_READ  = 2'd3
    } cmd_t;

    state_t state;
    cmd_t   cmd;
    logic   cmd_bit;
    logic   scl_oe;
    logic   sda_oe;
    logic   cmd_ready;
    logic   rsp_valid;
    logic   rsp_bit;
    logic   arb_lost;
    logic   busy;

    // {scl_oe, sda_oe} to drive while in phase ph of command c.
    function automatic logic [1:0] levels(input cmd_t c, input logic b, input state_t ph);
        logic scl_low;
        logic sda_low;
        scl_low = (ph == ST_PH_A) || (ph == ST_PH_D);
        case (c)
            CMD_START: sda_low = (ph == ST_PH_C) || (ph == ST_PH_D);
            CMD_STOP: begin
                scl_low = (ph == ST_PH_A);
                sda_low = (ph == ST_PH_A) || (ph == ST_PH_B);
            end
            CMD_WRITE: sda_low = ~b;
            default:   sda_low = 1'b0;
        endcase
        return {scl_low, sda_low};
    endfunction

    // Phase sequencer with registered line enables and response outputs.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state     <= ST_IDLE;
            cmd       <= CMD_START;
            cmd_bit   <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_bit   <= 1'b0;
            arb_lost  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // cmd_ready is low in the response cycle, so it rises one cycle later
                    cmd_ready <= 1'b1;
                    if (bus.cmd_valid_i && cmd_ready) begin
                        cmd       <= cmd_t'(bus.cmd_i);
                        cmd_bit   <= bus.cmd_bit_i;
                        cmd_ready <= 1'b0;
                        state     <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (tick_i) begin
                        state            <= ST_PH_A;
                        {scl_oe, sda_oe} <= levels(cmd, cmd_bit, ST_PH_A);
                    end
                end
                ST_PH_A: begin
                    if (tick_i) begin
                        state            <= ST_PH_B;
                        {scl_oe, sda_oe} <= levels(cmd, cmd_bit, ST_PH_B);
                    end
                end
                ST_PH_B: begin
                    // a slave holding SCL low keeps us here until a tick sees it high
                    if (tick_i && bus.scl_i) begin
                        state            <= ST_PH_C;
                        {scl_oe, sda_oe} <= levels(cmd, cmd_bit, ST_PH_C);
                    end
                end
                ST_PH_C: begin
                    if (tick_i) begin
                        rsp_bit <= ((cmd == CMD_WRITE) || (cmd == CMD_READ)) && bus.sda_i;
                        if (((cmd == CMD_WRITE && cmd_bit) || cmd == CMD_STOP) && !bus.sda_i) begin
                            state     <= ST_IDLE;
                            scl_oe    <= 1'b0;
                            sda_oe    <= 1'b0;
                            rsp_valid <= 1'b1;
                            arb_lost  <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            state            <= ST_PH_D;
                            {scl_oe, sda_oe} <= levels(cmd, cmd_bit, ST_PH_D);
                        end
                    end
                end
                ST_PH_D: begin
                    // phase-D levels stay on the bus while idle
                    if (tick_i) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b1;
                        arb_lost  <= 1'b0;
                        if (cmd == CMD_START) begin
                            busy <= 1'b1;
                        end else if (cmd == CMD_STOP) begin
                            busy <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.scl_oe_o    = scl_oe;
    assign bus.sda_oe_o    = sda_oe;
    assign bus.cmd_ready_o = cmd_ready;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_bit_o   = rsp_bit;
    assign bus.arb_lost_o  = arb_lost;
    assign bus.busy_o      = busy;
endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Self-checking bench for i2c_bit_ctrl: directed vector table, reset corner
// case and randomized commands checked against a behavioural bus model.
module tb_i2c_bit_ctrl;
    logic clk;
    logic rst_n;
    logic tick;
    logic stretch;
    logic slave_low;

    int checks;
    int errors;
    bit model_busy;

    i2c_bit_ctrl_if bus ();

    i2c_bit_ctrl dut (
        .clk_i   (clk),
        .arstn_i (rst_n),
        .tick_i  (tick),
        .bus     (bus)
    );

    // Wired-AND bus: a line is high unless the master or a slave pulls it.
    assign bus.scl_i = ~bus.scl_oe_o & ~stretch;
    assign bus.sda_i = ~bus.sda_oe_o & ~slave_low;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int c;
        bit b;
        bit low;
        int stretch;
        bit tick_acc;
        int exp_ticks;
        bit exp_bit;
        bit exp_arb;
        bit exp_busy;
    } vec_t;

    vec_t vec[15];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Line table as (SCL,SDA) pairs for phases A..D, L = pulled low.
    function automatic logic [1:0] exp_lv(input int c, input bit b, input int ph);
        string s;
        case (c)
            0:       s = "LRRRRLLL";
            1:       s = "LLRLRRRR";
            2:       s = b ? "LRRRRRLR" : "LLRLRLLL";
            default: s = "LRRRRRLR";
        endcase
        return {s[2*ph] == "L", s[2*ph+1] == "L"};
    endfunction

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic run_cmd(input string tag, input int c, input bit b, input bit low,
                           input int st, input bit tick_acc, input int exp_ticks,
                           input bit exp_bit, input bit exp_arb, input bit exp_busy);
        int waited;
        int n;
        int ph;
        bit done;
        logic [1:0] lv;
        logic [1:0] final_lv;
        slave_low = low;
        waited = 0;
        while (!bus.cmd_ready_o && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " ready"}, bus.cmd_ready_o, 1);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_i       = c[1:0];
        bus.cmd_bit_i   = b;
        tick            = tick_acc;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        tick            = 1'b0;
        check({tag, " accept"}, {bus.cmd_ready_o, bus.rsp_valid_o}, 2'b00);
        repeat (3) @(negedge clk);
        done = 1'b0;
        n = 0;
        while (!done && n < exp_ticks + 4) begin
            n++;
            stretch = (n >= 3) && (n <= 2 + st);
            pulse_tick();
            if (bus.rsp_valid_o) begin
                done = 1'b1;
            end else if (n < exp_ticks) begin
                if (n == 1) ph = 0;
                else if (n <= 2 + st) ph = 1;
                else ph = n - 1 - st;
                lv = exp_lv(c, b, ph);
                check($sformatf("%s tick%0d", tag, n),
                      {bus.scl_oe_o, bus.sda_oe_o, bus.cmd_ready_o}, {lv, 1'b0});
            end
            if (!done) repeat (3) @(negedge clk);
        end
        stretch = 1'b0;
        check({tag, " ticks"}, done ? n : 0, exp_ticks);
        if (done) begin
            final_lv = exp_arb ? 2'b00 : exp_lv(c, b, 3);
            check({tag, " rsp"},
                  {bus.rsp_bit_o, bus.arb_lost_o, bus.busy_o, bus.cmd_ready_o,
                   bus.scl_oe_o, bus.sda_oe_o},
                  {exp_bit, exp_arb, exp_busy, 1'b0, final_lv});
            @(negedge clk);
            check({tag, " pulse"}, {bus.rsp_valid_o, bus.cmd_ready_o}, 2'b01);
        end
        slave_low = 1'b0;
    endtask

    initial begin
        int c;
        bit b;
        bit low;
        int st;
        logic [1:0] lv_c;
        bit line_c;
        bit arb;
        bit rbit;

        checks          = 0;
        errors          = 0;
        tick            = 1'b0;
        stretch         = 1'b0;
        slave_low       = 1'b0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_i       = 2'd0;
        bus.cmd_bit_i   = 1'b0;
        rst_n           = 1'b0;

        //              c  b  low st acc ticks bit arb busy
        vec[0]  = '{0, 0, 0, 0, 0, 5, 0, 0, 1};
        vec[1]  = '{2, 1, 0, 0, 0, 5, 1, 0, 1};
        vec[2]  = '{2, 0, 0, 0, 0, 5, 0, 0, 1};
        vec[3]  = '{2, 1, 0, 0, 0, 5, 1, 0, 1};
        vec[4]  = '{2, 1, 0, 0, 1, 5, 1, 0, 1};
        vec[5]  = '{2, 0, 0, 0, 0, 5, 0, 0, 1};
        vec[6]  = '{2, 0, 0, 0, 0, 5, 0, 0, 1};
        vec[7]  = '{2, 1, 0, 0, 0, 5, 1, 0, 1};
        vec[8]  = '{2, 0, 0, 0, 0, 5, 0, 0, 1};
        vec[9]  = '{3, 0, 1, 0, 0, 5, 0, 0, 1};
        vec[10] = '{2, 1, 0, 3, 1, 8, 1, 0, 1};
        vec[11] = '{2, 1, 1, 0, 0, 4, 0, 1, 0};
        vec[12] = '{0, 0, 0, 0, 0, 5, 0, 0, 1};
        vec[13] = '{0, 0, 0, 0, 0, 5, 0, 0, 1};
        vec[14] = '{1, 0, 0, 0, 0, 5, 0, 0, 0};

        repeat (3) @(negedge clk);
        check("reset outs",
              {bus.scl_oe_o, bus.sda_oe_o, bus.cmd_ready_o, bus.rsp_valid_o,
               bus.rsp_bit_o, bus.arb_lost_o, bus.busy_o}, 7'b0010000);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            run_cmd($sformatf("vec%0d", i), vec[i].c, vec[i].b, vec[i].low,
                    vec[i].stretch, vec[i].tick_acc, vec[i].exp_ticks,
                    vec[i].exp_bit, vec[i].exp_arb, vec[i].exp_busy);
        end

        // STOP whose released SDA is held low by another master
        run_cmd("start2", 0, 0, 0, 0, 0, 5, 0, 0, 1);
        run_cmd("stoparb", 1, 0, 1, 0, 0, 4, 0, 1, 0);

        // Asynchronous reset while a READ sits in phase C
        run_cmd("start3", 0, 0, 0, 0, 0, 5, 0, 0, 1);
        slave_low       = 1'b1;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_i       = 2'd3;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            pulse_tick();
            repeat (3) @(negedge clk);
        end
        check("rdC lines", {bus.scl_oe_o, bus.sda_oe_o, bus.busy_o, bus.cmd_ready_o}, 4'b0010);
        #2 rst_n = 1'b0;
        #1;
        check("async reset",
              {bus.scl_oe_o, bus.sda_oe_o, bus.cmd_ready_o, bus.rsp_valid_o,
               bus.rsp_bit_o, bus.arb_lost_o, bus.busy_o}, 7'b0010000);
        slave_low = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_cmd("postrst", 0, 0, 0, 0, 0, 5, 0, 0, 1);
        model_busy = 1'b1;

        // Random commands against the bus-level model
        for (int r = 0; r < 40; r++) begin
            c   = int'($urandom_range(0, 3));
            b   = 1'($urandom);
            low = 1'($urandom);
            st  = int'($urandom_range(0, 2));
            lv_c   = exp_lv(c, b, 2);
            line_c = ~lv_c[0] & ~low;
            arb    = ((c == 2 && b) || c == 1) && !line_c;
            rbit   = (c >= 2) ? line_c : 1'b0;
            if (arb) model_busy = 1'b0;
            else if (c == 0) model_busy = 1'b1;
            else if (c == 1) model_busy = 1'b0;
            run_cmd($sformatf("rnd%0d", r), c, b, low, st, 1'($urandom),
                    (arb ? 4 : 5) + st, rbit, arb, model_busy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case a handshake never completes
    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
